// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage for a simple in-order pipeline. It keeps a 32-bit byte PC and
//   reads a combinational instruction memory by word address. Fetched words
//   go to decode through a valid/ready handshake. A redirect with an aligned
//   target restarts fetch at that target. A redirect with a misaligned target
//   puts the block in a terminal FAULT state, and only reset clears it.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous assert, active-low reset
//   fetch_en       in   enable fetching
//   imem_addr      out  word address to instruction memory (pc[ADDR_WIDTH+1:2])
//   imem_instr     in   instruction memory read data, same cycle as imem_addr
//   redirect_valid in   branch/jump redirect request
//   redirect_pc    in   redirect target byte address
//   id_valid       out  id_instr/id_pc hold an instruction for decode
//   id_ready       in   decode accepts the instruction this cycle
//   id_instr       out  fetched instruction
//   id_pc          out  byte address of id_instr
//   fault          out  a misaligned redirect has been taken
//   fetch_count    out  number of instructions handed to decode (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [31:0]           id_pc,
    output logic                  fault,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                state_reg;
    logic [31:0]           pc_reg;
    logic                  id_valid_reg;
    logic [DATA_WIDTH-1:0] id_instr_reg;
    logic [31:0]           id_pc_reg;
    logic                  fault_reg;
    logic [31:0]           fetch_count_reg;

    logic handshake;
    logic redirect_misaligned;
    logic load;

    // The memory index is just the word part of the PC. High PC bits are
    // dropped, so the index wraps modulo 2^ADDR_WIDTH.
    assign imem_addr = pc_reg[ADDR_WIDTH+1:2];

    assign handshake           = id_valid_reg & id_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // The output register can take a new word if it is empty or is being
    // drained this cycle. A redirect always wins over a load.
    assign load = (state_reg == RUN) & fetch_en & ~redirect_valid
                & (~id_valid_reg | id_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            id_valid_reg    <= 1'b0;
            id_instr_reg    <= '0;
            id_pc_reg       <= '0;
            fault_reg       <= 1'b0;
            fetch_count_reg <= '0;
        end else if (state_reg != FAULT) begin
            // Count a handshake even when a redirect flushes in the same cycle.
            // The word has already been accepted by decode.
            if (handshake) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end

            if (redirect_valid) begin
                id_valid_reg <= 1'b0;
                if (redirect_misaligned) begin
                    state_reg <= FAULT;
                    fault_reg <= 1'b1;
                end else begin
                    pc_reg <= redirect_pc;
                end
            end else if (load) begin
                id_instr_reg <= imem_instr;
                id_pc_reg    <= pc_reg;
                id_valid_reg <= 1'b1;
                pc_reg       <= pc_reg + 32'd4;
            end else begin
                if (handshake) begin
                    id_valid_reg <= 1'b0;
                end
                case (state_reg)
                    IDLE:    if (fetch_en)  state_reg <= RUN;
                    RUN:     if (!fetch_en) state_reg <= IDLE;
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign id_valid    = id_valid_reg;
    assign id_instr    = id_instr_reg;
    assign id_pc       = id_pc_reg;
    assign fault       = fault_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    // Memory word k holds 32'h1000_0000 + k.
    assign imem_instr = 32'h1000_0000 + {22'd0, imem_addr};

    instruction_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
            $display("check %-22s act=%08h req=%08h ok", name, act, req);
        end else begin
            $display("FAIL %-22s act=%08h req=%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: a handshake that is visible at the falling edge completes on
    // the next rising edge. Compare it against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL hs_unexpected          pc=%08h instr=%08h req=none", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("hs_pc", id_pc, e.pc);
                    check("hs_instr", id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        int cyc;
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        step();
        rst_n = 1'b1;

        // ---------------- streaming ----------------
        for (int k = 0; k < 8; k++) push(32'(4 * k), 32'h1000_0000 + 32'(k));
        fetch_en = 1'b1;
        id_ready = 1'b1;
        step();
        check("stream_no_early_load", {31'd0, id_valid}, 32'd0);
        cyc = 1;
        while (fetch_count != 32'd8 && cyc < 40) begin
            step();
            cyc++;
        end
        check("stream_count", fetch_count, 32'd8);
        check("stream_cycles", 32'(cyc), 32'd10);
        check("stream_pending_pc", id_pc, 32'd32);

        // ---------------- async reset mid-stream ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_id_valid", {31'd0, id_valid}, 32'd0);
        check("areset_fetch_count", fetch_count, 32'd0);
        check("areset_imem_addr", {22'd0, imem_addr}, 32'd0);
        do_reset();
        step();
        check("areset_idle", {31'd0, id_valid}, 32'd0);

        // ---------------- stall ----------------
        do_reset();
        push(32'h0, 32'h1000_0000);
        push(32'h4, 32'h1000_0001);
        push(32'h8, 32'h1000_0002);
        push(32'hC, 32'h1000_0003);
        fetch_en = 1'b1;
        id_ready = 1'b1;
        cyc = 0;
        while (!(id_valid && id_pc == 32'd8) && cyc < 20) begin
            step();
            cyc++;
        end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_id_pc", id_pc, 32'd8);
            check("stall_id_instr", id_instr, 32'h1000_0002);
            check("stall_imem_addr", {22'd0, imem_addr}, 32'd3);
            check("stall_id_valid", {31'd0, id_valid}, 32'd1);
        end
        id_ready = 1'b1;
        step();
        check("stall_next_pc", id_pc, 32'd12);
        step();
        check("stall_count", fetch_count, 32'd4);

        // ---------------- redirect ----------------
        do_reset();
        push(32'h0,  32'h1000_0000);
        push(32'h40, 32'h1000_0010);
        push(32'h44, 32'h1000_0011);
        fetch_en = 1'b1;
        id_ready = 1'b0;
        step();
        step();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("redir_pending_pc", id_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        check("redir_flush", {31'd0, id_valid}, 32'd0);
        check("redir_imem_addr", {22'd0, imem_addr}, 32'd16);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        step();
        check("redir_first_pc", id_pc, 32'h40);
        step();
        step();
        check("redir_count", fetch_count, 32'd3);

        // ---------------- misaligned redirect ----------------
        do_reset();
        push(32'h0, 32'h1000_0000);
        fetch_en = 1'b1;
        id_ready = 1'b1;
        step();
        step();
        step();
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_id_valid", {31'd0, id_valid}, 32'd0);
        check("mis_count", fetch_count, 32'd1);
        redirect_pc = 32'h80;
        id_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_id_valid", {31'd0, id_valid}, 32'd0);
            check("fault_sticky", {31'd0, fault}, 32'd1);
            check("fault_count", fetch_count, 32'd1);
            check("fault_imem_addr", {22'd0, imem_addr}, 32'd2);
        end
        do_reset();
        check("fault_cleared", {31'd0, fault}, 32'd0);

        // ---------------- wrap ----------------
        push(32'hFFC,       32'h1000_03FF);
        push(32'h1000,      32'h1000_0000);
        push(32'hFFFF_FFFC, 32'h1000_03FF);
        push(32'h0,         32'h1000_0000);
        fetch_en       = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFC;
        step();
        check("wrap_addr_top", {22'd0, imem_addr}, 32'd1023);
        redirect_valid = 1'b0;
        step();
        step();
        check("wrap_addr_zero", {22'd0, imem_addr}, 32'd0);
        check("wrap_id_pc", id_pc, 32'hFFC);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap32_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap32_imem_addr", {22'd0, imem_addr}, 32'd0);
        step();
        check("wrap32_next_pc", id_pc, 32'h0);
        step();
        check("wrap_count", fetch_count, 32'd4);

        do_reset();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
